// File: rtl/circular_fifo_if.sv
// rtl/circular_fifo_if.sv - producer/consumer handshake bundle for circular_fifo
interface circular_fifo_if #(
    parameter int DATA_W = 4
);
    logic [DATA_W-1:0] data_in;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] data_out;
    logic              empty;
    logic              full;

    // Producer/consumer side drives requests and write data, observes status
    modport master (
        output data_in,
        output wr_en,
        output rd_en,
        input  data_out,
        input  empty,
        input  full
    );

    // FIFO side samples requests and returns read data and flags
    modport slave (
        input  data_in,
        input  wr_en,
        input  rd_en,
        output data_out,
        output empty,
        output full
    );
endinterface

// File: rtl/circular_fifo.sv
// rtl/circular_fifo.sv - single-clock circular-buffer FIFO with wrap-bit pointers
module circular_fifo #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    circular_fifo_if.slave        bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [DATA_W-1:0] data_out_q;

    logic empty_w;
    logic full_w;
    logic rd_acc;
    logic wr_acc;

    // Flags decode straight from the registered pointers; the MSB tells a
    // completely full buffer apart from an empty one when the indices match.
    assign empty_w = (wr_ptr == rd_ptr);
    assign full_w  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                     (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

    // A read frees a slot in the same edge, so a full FIFO still takes a write
    // when it is also being read.
    assign rd_acc = bus.rd_en && !empty_w;
    assign wr_acc = bus.wr_en && (!full_w || rd_acc);

    assign bus.data_out = data_out_q;
    assign bus.empty    = empty_w;
    assign bus.full     = full_w;

    // Storage is never cleared; stale contents are unreachable once pointers reset
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_W-1:0]] <= bus.data_in;
        end
    end

    // Pointer advance and registered read data, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_out_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
            end
            if (rd_acc) begin
                rd_ptr     <= rd_ptr + (ADDR_W+1)'(1);
                data_out_q <= mem[rd_ptr[ADDR_W-1:0]];
            end
        end
    end
endmodule

// File: tb/tb_circular_fifo.sv
// tb/tb_circular_fifo.sv - directed and random checks of circular_fifo against a queue model
`timescale 1ns/1ps
module tb_circular_fifo;
    localparam int DATA_W = 4;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk;
    logic rst;

    circular_fifo_if #(.DATA_W(DATA_W)) bus ();

    circular_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] exp_dout;
    int n_cmp;
    int n_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " data_out"}, 32'(bus.data_out), 32'(exp_dout));
        check({tag, " empty"},    32'(bus.empty),    32'(q.size() == 0));
        check({tag, " full"},     32'(bus.full),     32'(q.size() == DEPTH));
    endtask

    // One clock edge: drive requests, let the edge happen, update the queue
    // model from the pre-edge occupancy, then compare just after the edge.
    task automatic step(input string tag, input logic w, input logic r, input logic [DATA_W-1:0] d);
        bit rd_ok;
        bit wr_ok;
        bus.wr_en   = w;
        bus.rd_en   = r;
        bus.data_in = d;
        @(posedge clk);
        rd_ok = r && (q.size() > 0);
        wr_ok = w && ((q.size() < DEPTH) || rd_ok);
        if (rd_ok) exp_dout = q.pop_front();
        if (wr_ok) q.push_back(d);
        #1;
        check_all(tag);
    endtask

    logic [DATA_W-1:0] fill_pat [8];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_dout = '0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.data_in = '0;
        fill_pat = '{4'd0, 4'd11, 4'd6, 4'd5, 4'd9, 4'd7, 4'd5, 4'd11};

        // Reset held across the first edge so the clear is certain
        rst = 1'b1;
        #1 rst = 1'b0;
        #6 rst = 1'b1;
        #1;
        check_all("reset");

        step("rd_empty", 1'b0, 1'b1, 4'd0);
        step("rd_empty2", 1'b0, 1'b1, 4'd0);

        for (int i = 0; i < 8; i++) step("fill", 1'b1, 1'b0, fill_pat[i]);
        step("wr_full_ignored", 1'b1, 1'b0, 4'd8);
        for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, 4'd0);
        step("rd_after_drain", 1'b0, 1'b1, 4'd0);

        step("conc_pre", 1'b1, 1'b0, 4'd2);
        step("conc_pre", 1'b1, 1'b0, 4'd3);
        step("conc_pre", 1'b1, 1'b0, 4'd13);
        step("conc_rw", 1'b1, 1'b1, 4'd11);
        step("conc_rw", 1'b1, 1'b1, 4'd8);
        for (int i = 0; i < 3; i++) step("conc_drain", 1'b0, 1'b1, 4'd0);
        step("rw_empty", 1'b1, 1'b1, 4'd9);
        step("rw_empty_drain", 1'b0, 1'b1, 4'd0);

        for (int i = 0; i < 8; i++) step("full_fill", 1'b1, 1'b0, 4'($urandom_range(0, 15)));
        step("full_rw", 1'b1, 1'b1, 4'd6);
        for (int i = 0; i < 8; i++) step("full_drain", 1'b0, 1'b1, 4'd0);

        step("wrap_pre", 1'b1, 1'b0, 4'($urandom_range(0, 15)));
        step("wrap_pre", 1'b1, 1'b0, 4'($urandom_range(0, 15)));
        for (int i = 0; i < 20; i++) step("wrap_rw", 1'b1, 1'b1, 4'($urandom_range(0, 15)));
        for (int i = 0; i < 3; i++) step("wrap_drain", 1'b0, 1'b1, 4'd0);

        for (int i = 0; i < 300; i++) begin
            step("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)));
        end

        // Build a known nonzero data_out, leave 4 entries, then reset between edges
        while (q.size() > 0) step("pre_rst_drain", 1'b0, 1'b1, 4'd0);
        step("pre_rst_fill", 1'b1, 1'b0, 4'd12);
        step("pre_rst_rd", 1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 4; i++) step("pre_rst_fill", 1'b1, 1'b0, 4'($urandom_range(1, 15)));
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        #1 rst = 1'b0;
        #1;
        q.delete();
        exp_dout = '0;
        check_all("async_rst");
        #1 rst = 1'b1;
        step("post_rst_rd", 1'b0, 1'b1, 4'd0);
        step("post_rst_wr", 1'b1, 1'b0, 4'd10);
        step("post_rst_rd", 1'b0, 1'b1, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
